vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Parametrised VGA raster timing generator. Produces pixel column/row
//  addresses plus hsync, vsync, visible and line/frame strobes from four
//  porch/sync parameters per axis, so any mode can be built from one block.
//  Adds a pixel-clock enable, so the block runs from the system clock. Sits
//  between the clock domain root and the framebuffer/pattern logic and the
//  VGA output pins.
// PARAMETERS
//  H_VISIBLE      640  visible pixels per line
//  H_FRONT_PORCH  16   pixels, visible end -> hsync start
//  H_SYNC_PULSE   96   hsync width in pixels
//  H_BACK_PORCH   48   pixels, hsync end -> next line
//  V_VISIBLE      480  visible lines per frame
//  V_FRONT_PORCH  10   lines, visible end -> vsync start
//  V_SYNC_PULSE   2    vsync width in lines
//  V_BACK_PORCH   33   lines, vsync end -> next frame
//  H_SYNC_POL     0    hsync active level (0 = active-low)
//  V_SYNC_POL     0    vsync active level
//  COL_W          10   column width; must hold H_TOTAL-1 (elaboration $error otherwise)
//  ROW_W          10   row width; must hold V_TOTAL-1 (elaboration $error otherwise)
// PORTS
//  clk        in   1      system clock
//  reset      in   1      async, active-high
//  pix_en     in   1      pixel advance enable; tie 1 for one pixel/clk
//  column     out  COL_W  current column 0..H_TOTAL-1
//  row        out  ROW_W  current row 0..V_TOTAL-1
//  visible    out  1      column<H_VISIBLE && row<V_VISIBLE
//  hsync      out  1      horizontal sync, level per H_SYNC_POL
//  vsync      out  1      vertical sync, level per V_SYNC_POL
//  line_end   out  1      1-clk pulse on the cycle column wraps
//  frame_end  out  1      1-clk pulse on the cycle column and row both wrap
// BEHAVIOUR
//  - H_TOTAL = sum of the four H_* params; V_TOTAL likewise.
//  - Interface: one clock (clk); reset is asynchronous and active-high.
//  - Reset (async, immediate): column=0, row=0, hsync=~H_SYNC_POL,
//    vsync=~V_SYNC_POL, visible=0, line_end=0, frame_end=0.
//  - Counters change only on clk edges with pix_en=1. column+1, wrapping
//    H_TOTAL-1 -> 0. row advances only on the column wrap, wrapping V_TOTAL-1 -> 0.
//  - pix_en=0: all counters hold; strobes are 0.
//  - line_end = pix_en && column==H_TOTAL-1. This is one clk wide regardless
//    of pix_en rate. frame_end = line_end && row==V_TOTAL-1.
//  - hsync active for column in [H_VISIBLE+H_FRONT_PORCH, +H_SYNC_PULSE-1].
//    vsync active for row in [V_VISIBLE+V_FRONT_PORCH, +V_SYNC_PULSE-1].
//  - hsync/vsync/visible decode the current column/row, with zero latency.
//    They are forced inactive while reset is high. They are glitch-free
//    (driven from flops or a decode of flops only).
//  - Reset deasserted mid-frame: the raster restarts at column 0, row 0.
//    The first line_end comes H_TOTAL pix_en steps later.
// CONFIGURATION
//  VGA_TIMING_LOOKAHEAD_EN defined: hsync, vsync and visible pass through
//    one flop enabled by pix_en (reset: inactive, visible=0). They lag
//    column/row by one pixel step, which aligns them with data from a
//    1-cycle synchronous framebuffer read. line_end/frame_end are unchanged.
//  Undefined: zero-latency decode as above; no extra flops.
// TESTING (H 4/1/2/1 -> H_TOTAL=8; V 3/1/1/1 -> V_TOTAL=6)
//  1 reset, pix_en=1 -> column 0..7,0; hsync=0 only at col 5,6; line_end only at col 7
//  2 run 48 clks -> row 0..5,0 on column wraps; vsync=0 only row 4; frame_end once at (7,5)
//  3 pix_en on alternate clks -> column steps every 2 clks; line_end exactly 1 clk per line
//  4 H_SYNC_POL=1 -> hsync=1 only at col 5,6; visible=1 only col<4 && row<3
//  5 reset at (col 3,row 2) -> outputs at reset values same cycle, no clk edge; restart at 0,0
//  6 VGA_TIMING_LOOKAHEAD_EN -> hsync=0 at col 6,7; visible=1 at col 1..4 of rows 0..2
//     (row-0 wrap to col 0 shows prior-line visible=0)

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// ---------------------------------------------------------------------------
// Parametrised VGA raster timing generator running from the system clock with
// a pixel-advance enable. A column counter walks 0..H_TOTAL-1 and a row counter
// steps once per column wrap through 0..V_TOTAL-1. hsync, vsync and visible are
// decoded from those counters. line_end and frame_end mark the pixel step on
// which the column (and the row) wraps.
//
// Optional feature (compile-time macro VGA_TIMING_LOOKAHEAD_EN):
//   defined   - hsync/vsync/visible are registered on pix_en and lag
//               column/row by one pixel step. This lines them up with pixel
//               data from a framebuffer that has a one-cycle read latency.
//   undefined - hsync/vsync/visible are a zero-latency decode of the counters.
//
// Ports
//   clk        in   1      system clock
//   reset      in   1      asynchronous, active-high
//   pix_en     in   1      pixel advance enable (tie 1 for one pixel per clock)
//   column     out  COL_W  current column, 0..H_TOTAL-1
//   row        out  ROW_W  current row, 0..V_TOTAL-1
//   visible    out  1      column < H_VISIBLE and row < V_VISIBLE
//   hsync      out  1      horizontal sync, active level H_SYNC_POL
//   vsync      out  1      vertical sync, active level V_SYNC_POL
//   line_end   out  1      high for one clock on the step where column wraps
//   frame_end  out  1      high for one clock when column and row both wrap
// ---------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int H_VISIBLE     = 640,
    parameter int H_FRONT_PORCH = 16,
    parameter int H_SYNC_PULSE  = 96,
    parameter int H_BACK_PORCH  = 48,
    parameter int V_VISIBLE     = 480,
    parameter int V_FRONT_PORCH = 10,
    parameter int V_SYNC_PULSE  = 2,
    parameter int V_BACK_PORCH  = 33,
    parameter bit H_SYNC_POL    = 1'b0,
    parameter bit V_SYNC_POL    = 1'b0,
    parameter int COL_W         = 10,
    parameter int ROW_W         = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pix_en,
    output logic [COL_W-1:0] column,
    output logic [ROW_W-1:0] row,
    output logic             visible,
    output logic             hsync,
    output logic             vsync,
    output logic             line_end,
    output logic             frame_end
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH;

    // Sync windows as [start, stop) in plain integers so the end bound
    // cannot overflow the counter width.
    localparam int HS_START = H_VISIBLE + H_FRONT_PORCH;
    localparam int HS_STOP  = HS_START + H_SYNC_PULSE;
    localparam int VS_START = V_VISIBLE + V_FRONT_PORCH;
    localparam int VS_STOP  = VS_START + V_SYNC_PULSE;

    localparam logic [COL_W-1:0] H_LAST = COL_W'(H_TOTAL - 1);
    localparam logic [ROW_W-1:0] V_LAST = ROW_W'(V_TOTAL - 1);

    generate
        if (H_TOTAL - 1 >= (1 << COL_W)) begin : g_col_w_too_small
            $error("vga_timing_gen: COL_W cannot hold H_TOTAL-1");
        end
        if (V_TOTAL - 1 >= (1 << ROW_W)) begin : g_row_w_too_small
            $error("vga_timing_gen: ROW_W cannot hold V_TOTAL-1");
        end
    endgenerate

    logic col_last;
    logic row_last;

    assign col_last = (column == H_LAST);
    assign row_last = (row == V_LAST);

    // Raster counters: everything moves only on an enabled pixel step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            column <= '0;
            row    <= '0;
        end else if (pix_en) begin
            if (col_last) begin
                column <= '0;
                row    <= row_last ? '0 : row + 1'b1;
            end else begin
                column <= column + 1'b1;
            end
        end
    end

    // The strobe mirrors pix_en, so it is exactly one clock wide however
    // sparsely pix_en is asserted.
    assign line_end  = pix_en & col_last & ~reset;
    assign frame_end = line_end & row_last;

    // Decode of the current raster position (active-high internal sense).
    logic hs_act;
    logic vs_act;
    logic vis_act;

    assign hs_act  = (int'(column) >= HS_START) && (int'(column) < HS_STOP);
    assign vs_act  = (int'(row) >= VS_START) && (int'(row) < VS_STOP);
    assign vis_act = (int'(column) < H_VISIBLE) && (int'(row) < V_VISIBLE);

`ifdef VGA_TIMING_LOOKAHEAD_EN
    logic hsync_q;
    logic vsync_q;
    logic visible_q;

    // One pixel step of delay to match a synchronous framebuffer read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hsync_q   <= ~H_SYNC_POL;
            vsync_q   <= ~V_SYNC_POL;
            visible_q <= 1'b0;
        end else if (pix_en) begin
            hsync_q   <= hs_act ? H_SYNC_POL : ~H_SYNC_POL;
            vsync_q   <= vs_act ? V_SYNC_POL : ~V_SYNC_POL;
            visible_q <= vis_act;
        end
    end

    assign hsync   = hsync_q;
    assign vsync   = vsync_q;
    assign visible = visible_q;
`else
    // Counters sit at (0,0) during reset, which would otherwise decode as
    // visible, so the decode is gated off while reset is high.
    assign hsync   = (hs_act & ~reset) ? H_SYNC_POL : ~H_SYNC_POL;
    assign vsync   = (vs_act & ~reset) ? V_SYNC_POL : ~V_SYNC_POL;
    assign visible = vis_act & ~reset;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
// ---------------------------------------------------------------------------
// Bench for vga_timing_gen with a tiny raster (H 4/1/2/1 -> 8 columns,
// V 3/1/1/1 -> 6 rows). Two instances share the stimulus: dut_a uses
// active-low syncs, dut_b active-high syncs. Expected values come from a
// hand-filled vector table and from a model that derives the raster position
// from the number of enabled pixel steps since reset.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

    localparam int HV = 4, HF = 1, HS = 2, HB = 1;
    localparam int VV = 3, VF = 1, VS = 1, VB = 1;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    logic pix_en;

    always #5 clk = ~clk;

    logic [2:0] col_a, row_a, col_b, row_b;
    logic       vis_a, hs_a, vs_a, le_a, fe_a;
    logic       vis_b, hs_b, vs_b, le_b, fe_b;

    vga_timing_gen #(
        .H_VISIBLE(HV), .H_FRONT_PORCH(HF), .H_SYNC_PULSE(HS), .H_BACK_PORCH(HB),
        .V_VISIBLE(VV), .V_FRONT_PORCH(VF), .V_SYNC_PULSE(VS), .V_BACK_PORCH(VB),
        .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0), .COL_W(3), .ROW_W(3)
    ) dut_a (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .column(col_a), .row(row_a), .visible(vis_a), .hsync(hs_a), .vsync(vs_a),
        .line_end(le_a), .frame_end(fe_a)
    );

    vga_timing_gen #(
        .H_VISIBLE(HV), .H_FRONT_PORCH(HF), .H_SYNC_PULSE(HS), .H_BACK_PORCH(HB),
        .V_VISIBLE(VV), .V_FRONT_PORCH(VF), .V_SYNC_PULSE(VS), .V_BACK_PORCH(VB),
        .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .COL_W(3), .ROW_W(3)
    ) dut_b (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .column(col_b), .row(row_b), .visible(vis_b), .hsync(hs_b), .vsync(vs_b),
        .line_end(le_b), .frame_end(fe_b)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: raster position is just the step count modulo the totals.
    // With the lookahead build the decoded signals describe the previous step.
    function automatic void model(input int n, output int col, output int row,
                                  output bit vis, output bit hs_on, output bit vs_on);
        int m;
        col = n % HT;
        row = (n / HT) % VT;
        m = n;
`ifdef VGA_TIMING_LOOKAHEAD_EN
        m = n - 1;
`endif
        if (m < 0) begin
            vis = 1'b0; hs_on = 1'b0; vs_on = 1'b0;
        end else begin
            vis   = ((m % HT) < HV) && (((m / HT) % VT) < VV);
            hs_on = ((m % HT) >= HV + HF) && ((m % HT) < HV + HF + HS);
            vs_on = (((m / HT) % VT) >= VV + VF) && (((m / HT) % VT) < VV + VF + VS);
        end
    endfunction

    task automatic check_model(input string tag, input int n);
        int col, row;
        bit vis, hs_on, vs_on, le, fe;
        model(n, col, row, vis, hs_on, vs_on);
        le = pix_en && (col == HT - 1);
        fe = le && (row == VT - 1);
        chk({tag, "_col_a"}, col_a, col);
        chk({tag, "_row_a"}, row_a, row);
        chk({tag, "_col_b"}, col_b, col);
        chk({tag, "_row_b"}, row_b, row);
        chk({tag, "_vis_a"}, vis_a, vis);
        chk({tag, "_vis_b"}, vis_b, vis);
        chk({tag, "_hs_a"}, hs_a, !hs_on);
        chk({tag, "_vs_a"}, vs_a, !vs_on);
        chk({tag, "_hs_b"}, hs_b, hs_on);
        chk({tag, "_vs_b"}, vs_b, vs_on);
        chk({tag, "_le_a"}, le_a, le);
        chk({tag, "_fe_a"}, fe_a, fe);
        chk({tag, "_le_b"}, le_b, le);
        chk({tag, "_fe_b"}, fe_b, fe);
    endtask

    // ---------------- driver tasks ----------------
    // Leaves the bench at a falling edge with the raster at step 0, pix_en=0.
    task automatic do_reset();
        @(negedge clk);
        pix_en = 1'b0;
        reset  = 1'b1;
        @(negedge clk);
        reset  = 1'b0;
    endtask

    // ---------------- vector table ----------------
    // steps = enabled pixel steps since reset; sync levels are for dut_a
    // (active-low). Sampled with pix_en=1.
    typedef struct {
        int steps;
        int col;
        int row;
        bit hs;
        bit vs;
        bit vis;
        bit le;
        bit fe;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int cur;
        int le_cnt;
        int k;
        bit found;
        int n;
        int col, row;
        bit vis, hs_on, vs_on;

        //          steps col row hs vs vis le fe
        vecs[0]  = '{0,   0,  0,  1, 1, 1,  0, 0};
        vecs[1]  = '{3,   3,  0,  1, 1, 1,  0, 0};
        vecs[2]  = '{4,   4,  0,  1, 1, 0,  0, 0};
        vecs[3]  = '{5,   5,  0,  0, 1, 0,  0, 0};
        vecs[4]  = '{6,   6,  0,  0, 1, 0,  0, 0};
        vecs[5]  = '{7,   7,  0,  1, 1, 0,  1, 0};
        vecs[6]  = '{8,   0,  1,  1, 1, 1,  0, 0};
        vecs[7]  = '{19,  3,  2,  1, 1, 1,  0, 0};
        vecs[8]  = '{24,  0,  3,  1, 1, 0,  0, 0};
        vecs[9]  = '{37,  5,  4,  0, 0, 0,  0, 0};
        vecs[10] = '{47,  7,  5,  1, 1, 0,  1, 1};
        vecs[11] = '{48,  0,  0,  1, 1, 1,  0, 0};

        // Reset state, with pix_en high to show strobes stay low.
        reset  = 1'b1;
        pix_en = 1'b1;
        #1;
        chk("rst_col", col_a, 0);
        chk("rst_row", row_a, 0);
        chk("rst_vis", vis_a, 0);
        chk("rst_hs_a", hs_a, 1);
        chk("rst_vs_a", vs_a, 1);
        chk("rst_hs_b", hs_b, 0);
        chk("rst_vs_b", vs_b, 0);
        chk("rst_le", le_a, 0);
        chk("rst_fe", fe_a, 0);

        // Table-driven walk through one frame and the wrap back to (0,0).
        do_reset();
        pix_en = 1'b1;
        cur = 0;
        for (int i = 0; i < 12; i++) begin
            repeat (vecs[i].steps - cur) @(negedge clk);
            cur = vecs[i].steps;
            #1;
            chk("tbl_col", col_a, vecs[i].col);
            chk("tbl_row", row_a, vecs[i].row);
            chk("tbl_le", le_a, vecs[i].le);
            chk("tbl_fe", fe_a, vecs[i].fe);
            chk("tbl_le_b", le_b, vecs[i].le);
`ifndef VGA_TIMING_LOOKAHEAD_EN
            chk("tbl_hs_a", hs_a, vecs[i].hs);
            chk("tbl_vs_a", vs_a, vecs[i].vs);
            chk("tbl_vis_a", vis_a, vecs[i].vis);
            chk("tbl_hs_b", hs_b, !vecs[i].hs);
            chk("tbl_vs_b", vs_b, !vecs[i].vs);
            chk("tbl_vis_b", vis_b, vecs[i].vis);
`else
            model(cur, col, row, vis, hs_on, vs_on);
            chk("tbl_la_hs_a", hs_a, !hs_on);
            chk("tbl_la_vs_a", vs_a, !vs_on);
            chk("tbl_la_vis_a", vis_a, vis);
            chk("tbl_la_hs_b", hs_b, hs_on);
`endif
        end

        // pix_en on alternate clocks: column steps every 2 clocks and
        // line_end is a single clock per line.
        do_reset();
        le_cnt = 0;
        for (int i = 0; i < 4 * HT; i++) begin
            pix_en = (i % 2 == 0);
            #1;
            chk("alt_col", col_a, ((i + 1) / 2) % HT);
            if (le_a) le_cnt++;
            @(negedge clk);
        end
        chk("alt_le_count", le_cnt, 2);

        // Asynchronous reset mid-frame at (3,2), then restart from (0,0).
        do_reset();
        pix_en = 1'b1;
        repeat (19) @(negedge clk);
        #1;
        chk("mid_col", col_a, 3);
        chk("mid_row", row_a, 2);
        #2;
        reset = 1'b1;
        #1;
        chk("async_col", col_a, 0);
        chk("async_row", row_a, 0);
        chk("async_vis", vis_a, 0);
        chk("async_hs_a", hs_a, 1);
        chk("async_vs_a", vs_a, 1);
        chk("async_hs_b", hs_b, 0);
        chk("async_vs_b", vs_b, 0);
        chk("async_le", le_a, 0);
        chk("async_fe", fe_a, 0);
        @(negedge clk);
        reset  = 1'b0;
        pix_en = 1'b1;
        k = 0;
        found = 1'b0;
        for (int i = 0; i < 4 * HT && !found; i++) begin
            #1;
            if (le_a) found = 1'b1;
            else begin
                k++;
                @(negedge clk);
            end
        end
        chk("restart_le_seen", found, 1);
        chk("restart_steps", k + 1, HT);

        // Randomised pix_en against the step-count model.
        do_reset();
        n = 0;
        for (int i = 0; i < 700; i++) begin
            pix_en = 1'($urandom_range(0, 1));
            #1;
            check_model("rnd", n);
            @(posedge clk);
            if (pix_en) n++;
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
